// File: rtl/mesh_term_sink.sv
// mesh_term_sink
// Terminal-side receiver for one 4x4 mesh port. It drains the router's
// terminal output through the pndng/pop handshake, checks the destination
// address, and buffers accepted packets for a local valid/ready consumer.
//
// Optional feature macro: MESH_SINK_ADDR_CHECK_EN
//   defined   : packets whose target (row,col) differs from (ROW,COL) are
//               dropped and counted in misroute_cnt / pulsed on misroute.
//   undefined : every captured packet is accepted; misroute outputs tie to 0.
//
// Ports
//   clk          in   clock, rising edge
//   reset        in   asynchronous active-low reset
//   pndng        in   router has a head packet
//   data_out     in   router head packet (pckg_sz bits)
//   pop          out  consume router head (registered)
//   pkt_valid    out  local buffer non-empty
//   pkt_data     out  local buffer head, first-word-fall-through
//   pkt_ready    in   consumer takes head when pkt_valid
//   pkt_cnt      out  accepted-packet counter, wraps
//   misroute_cnt out  dropped-packet counter, saturates at 255
//   misroute     out  one-cycle pulse per dropped packet
module mesh_term_sink #(
  parameter int         pckg_sz    = 50,
  parameter int         fifo_depth = 4,
  parameter logic [3:0] ROW        = 4'd1,
  parameter logic [3:0] COL        = 4'd1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pndng,
  input  logic [pckg_sz-1:0] data_out,
  output logic               pop,
  output logic               pkt_valid,
  output logic [pckg_sz-1:0] pkt_data,
  input  logic               pkt_ready,
  output logic [15:0]        pkt_cnt,
  output logic [7:0]         misroute_cnt,
  output logic               misroute
);

  localparam int AW  = $clog2(fifo_depth);
  localparam int CW  = AW + 1;
  localparam int RHI = pckg_sz - 9;
  localparam int CHI = pckg_sz - 13;
  localparam logic [CW-1:0] DEPTH = CW'(fifo_depth);

  typedef enum logic [1:0] {IDLE, CAPT, GAP} state_t;

  state_t              state_q;
  logic                pop_q;
  logic [pckg_sz-1:0]  mem [fifo_depth];
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic [15:0]         pkt_cnt_q, pkt_cnt_d;

  logic addr_match;
  logic addr_ok;
  logic capt;
  logic wr_en;
  logic rd_en;

  always_comb begin
    addr_match = (data_out[RHI -: 4] == ROW) && (data_out[CHI -: 4] == COL);
    capt       = (state_q == CAPT);
    wr_en      = capt && addr_ok;
    rd_en      = (count_q != '0) && pkt_ready;
    wr_ptr_d   = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = rd_en ? rd_ptr_q + AW'(1) : rd_ptr_q;
    pkt_cnt_d  = wr_en ? pkt_cnt_q + 16'd1 : pkt_cnt_q;
    count_d    = count_q;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Handshake FSM. The space check looks only at the current count, so a
  // read in the same cycle never lets a capture overrun the buffer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pop_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pndng && (count_q != DEPTH)) begin
            pop_q   <= 1'b1;
            state_q <= CAPT;
          end else begin
            pop_q   <= 1'b0;
          end
        end
        CAPT: begin
          pop_q   <= 1'b0;
          state_q <= GAP;
        end
        GAP: begin
          pop_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          pop_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      pkt_cnt_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= data_out;
  end

`ifdef MESH_SINK_ADDR_CHECK_EN
  logic       mis_q;
  logic [7:0] mis_cnt_q;

  assign addr_ok = addr_match;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mis_q     <= 1'b0;
      mis_cnt_q <= '0;
    end else if (capt && !addr_match) begin
      mis_q <= 1'b1;
      if (mis_cnt_q != '1) mis_cnt_q <= mis_cnt_q + 8'd1;
    end else begin
      mis_q <= 1'b0;
    end
  end

  assign misroute     = mis_q;
  assign misroute_cnt = mis_cnt_q;
`else
  // Address comparison still evaluated, but every packet is accepted.
  assign addr_ok      = addr_match | 1'b1;
  assign misroute     = 1'b0;
  assign misroute_cnt = '0;
`endif

  assign pop       = pop_q;
  assign pkt_valid = (count_q != '0);
  assign pkt_data  = pkt_valid ? mem[rd_ptr_q] : '0;
  assign pkt_cnt   = pkt_cnt_q;

endmodule

// File: tb/tb_mesh_term_sink.sv
// Testbench for mesh_term_sink: a router model feeds packets through the
// pndng/pop handshake, a queue-based reference model predicts deliveries
// and counters, and a monitor checks every local read against the queue.
module tb_mesh_term_sink;

  localparam int W   = 50;
  localparam int RHI = W - 9;
  localparam int CHI = W - 13;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         pndng = 1'b0;
  logic [W-1:0] data_out = '0;
  logic         pkt_ready = 1'b0;
  logic         pop, pkt_valid, misroute;
  logic [W-1:0] pkt_data;
  logic [15:0]  pkt_cnt;
  logic [7:0]   misroute_cnt;

  mesh_term_sink #(.pckg_sz(W), .fifo_depth(4), .ROW(4'd1), .COL(4'd1)) dut (
    .clk(clk), .reset(reset), .pndng(pndng), .data_out(data_out), .pop(pop),
    .pkt_valid(pkt_valid), .pkt_data(pkt_data), .pkt_ready(pkt_ready),
    .pkt_cnt(pkt_cnt), .misroute_cnt(misroute_cnt), .misroute(misroute)
  );

  always #5 clk = ~clk;

  logic [W-1:0] rq[$];     // packets waiting inside the router
  logic [W-1:0] exp_q[$];  // packets expected at the local output, in order
  int exp_pkt = 0, exp_mis = 0, exp_pulses = 0, seen_pulses = 0;
  int errors = 0, checks = 0;
  int pop_rises = 0;
  bit prev_pop = 1'b0;
  bit gap_en = 1'b0;
  bit stream_mode = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic logic [W-1:0] mk(input logic [3:0] r, input logic [3:0] c);
    logic [63:0] x;
    logic [W-1:0] p;
    x = {$urandom(), $urandom()};
    p = x[W-1:0];
    p[RHI -: 4] = r;
    p[CHI -: 4] = c;
    return p;
  endfunction

  function automatic bit accepts(input logic [W-1:0] p);
`ifdef MESH_SINK_ADDR_CHECK_EN
    return (p[RHI -: 4] == 4'd1) && (p[CHI -: 4] == 4'd1);
`else
    return (p[0] | 1'b1);
`endif
  endfunction

  // Router model: the head is consumed on an edge where pop was high.
  always @(posedge clk) begin
    logic [W-1:0] p;
    #1;
    if (!reset) begin
      prev_pop = 1'b0;
      pndng    = 1'b0;
    end else begin
      if (prev_pop) begin
        chk("pop_with_packet", 64'(rq.size() != 0), 64'd1);
        if (rq.size() != 0) begin
          p = rq.pop_front();
          if (accepts(p)) begin
            exp_q.push_back(p);
            exp_pkt++;
          end else begin
            exp_mis = (exp_mis < 255) ? exp_mis + 1 : 255;
            exp_pulses++;
          end
        end
      end
      prev_pop = pop;
      if (rq.size() != 0) begin
        data_out = rq[0];
        pndng    = gap_en ? ($urandom_range(0, 3) != 0) : 1'b1;
      end else begin
        pndng = 1'b0;
      end
    end
  end

  // Monitor: pop spacing, output valid against the model, read data order.
  int  cyc = 0, last_rise = -100;
  bit  pop_d = 1'b0, last_in_stream = 1'b0;
  always @(negedge clk) begin
    logic [W-1:0] e;
    cyc++;
    if (!reset) begin
      last_rise = -100;
      pop_d     = 1'b0;
    end else begin
      if (pop && !pop_d) begin
        pop_rises++;
        if (last_rise >= 0) begin
          chk("pop_spacing_min", 64'((cyc - last_rise) >= 3), 64'd1);
          if (stream_mode && last_in_stream)
            chk("pop_spacing_stream", 64'(cyc - last_rise), 64'd3);
        end
        last_rise      = cyc;
        last_in_stream = stream_mode;
      end
      pop_d = pop;
      chk("valid_vs_model", 64'(pkt_valid), 64'(exp_q.size() != 0));
      if (pkt_valid && pkt_ready && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("pkt_data", 64'(pkt_data), 64'(e));
      end
      if (misroute) seen_pulses++;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((rq.size() != 0 || exp_q.size() != 0 || pop) && n < budget) begin
      step();
      n++;
    end
    chk("drain_in_budget", 64'(n < budget), 64'd1);
    repeat (3) step();
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "_pkt_cnt"}, 64'(pkt_cnt), 64'(exp_pkt & 'hFFFF));
    chk({tag, "_misroute_cnt"}, 64'(misroute_cnt), 64'(exp_mis));
    chk({tag, "_misroute_pulses"}, 64'(seen_pulses), 64'(exp_pulses));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] p;
    int base, n;

    // Reset values
    repeat (3) step();
    chk("rst_pop", 64'(pop), 64'd0);
    chk("rst_valid", 64'(pkt_valid), 64'd0);
    chk("rst_data", 64'(pkt_data), 64'd0);
    chk("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
    chk("rst_misroute_cnt", 64'(misroute_cnt), 64'd0);
    chk("rst_misroute", 64'(misroute), 64'd0);
    reset = 1'b1;
    step();

    // Single packet, target (1,1), payload 0x2A
    p = '0;
    p[RHI -: 4] = 4'd1;
    p[CHI -: 4] = 4'd1;
    p[7:0] = 8'h2A;
    pkt_ready = 1'b1;
    rq.push_back(p);
    drain(50);
    chk_counts("single");

    // Backpressure: four captures fill the buffer, then popping stops
    pkt_ready = 1'b0;
    base = pop_rises;
    for (int i = 0; i < 8; i++) rq.push_back(mk(4'd1, 4'd1));
    repeat (40) step();
    chk("bp_pops", 64'(pop_rises - base), 64'd4);
    chk("bp_pop_low", 64'(pop), 64'd0);
    chk_counts("bp_hold");
    pkt_ready = 1'b1;
    drain(200);
    chk_counts("bp_release");

    // Misroute
    rq.push_back(mk(4'd2, 4'd3));
    drain(50);
    chk_counts("misroute");

    // Saturation, then one good packet
    for (int i = 0; i < 300; i++) rq.push_back(mk(4'd2, 4'd3));
    drain(2000);
    chk_counts("saturate");
    rq.push_back(mk(4'd1, 4'd1));
    drain(50);
    chk_counts("after_sat");

    // Streaming: 20 back-to-back packets
    stream_mode = 1'b1;
    for (int i = 0; i < 20; i++) rq.push_back(mk(4'd1, 4'd1));
    drain(200);
    stream_mode = 1'b0;
    chk_counts("stream");

    // Randomized traffic, random consumer stalls and pndng gaps
    gap_en = 1'b1;
    for (int i = 0; i < 60; i++)
      rq.push_back(($urandom_range(0, 3) == 0) ?
                   mk(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))) :
                   mk(4'd1, 4'd1));
    n = 0;
    while (rq.size() != 0 && n < 3000) begin
      pkt_ready = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    chk("random_in_budget", 64'(n < 3000), 64'd1);
    gap_en = 1'b0;
    pkt_ready = 1'b1;
    drain(200);
    chk_counts("random");

    // Reset during CAPT with two packets buffered
    pkt_ready = 1'b0;
    rq.push_back(mk(4'd1, 4'd1));
    rq.push_back(mk(4'd1, 4'd1));
    n = 0;
    while (exp_q.size() != 2 && n < 100) begin step(); n++; end
    chk("two_buffered", 64'(exp_q.size()), 64'd2);
    rq.push_back(mk(4'd1, 4'd1));
    n = 0;
    while (!pop && n < 100) begin step(); n++; end
    chk("reached_capt", 64'(pop), 64'd1);
    #1 reset = 1'b0;
    #1;
    chk("arst_pop", 64'(pop), 64'd0);
    chk("arst_valid", 64'(pkt_valid), 64'd0);
    chk("arst_pkt_cnt", 64'(pkt_cnt), 64'd0);
    chk("arst_misroute_cnt", 64'(misroute_cnt), 64'd0);
    rq.delete();
    exp_q.delete();
    exp_pkt = 0;
    exp_mis = 0;
    exp_pulses = 0;
    seen_pulses = 0;
    repeat (3) step();
    reset = 1'b1;
    step();
    pkt_ready = 1'b1;
    rq.push_back(mk(4'd1, 4'd1));
    drain(50);
    chk_counts("post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mesh_term_sink.md
# mesh_term_sink

Terminal-side receiver for one port of the 4x4 mesh: drains packets the router presents on its terminal output (`pndng`/`data_out`) by issuing `pop`, checks the destination address against its own terminal ID, and buffers accepted packets for a local consumer behind a valid/ready interface. One instance sits on each of the 16 terminal outputs. It is the consuming end of the same pending/pop handshake that terminal sources use to inject packets.

## Interface
- `pckg_sz`, 50: packet width in bits.
- `fifo_depth`, 4: local buffer depth in packets; power of two, ≥2.
- `ROW`, 4'd1: this terminal's row ID.
- `COL`, 4'd1: this terminal's column ID.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `pndng`  in  1  router has a packet at the head of its terminal output.
- `data_out`  in  pckg_sz  head packet from the router; valid while `pndng`=1.
- `pop`  out  1  consume the router head; registered.
- `pkt_valid`  out  1  local buffer non-empty.
- `pkt_data`  out  pckg_sz  local buffer head, first-word-fall-through.
- `pkt_ready`  in  1  consumer takes the head when `pkt_valid`=1.
- `pkt_cnt`  out  16  accepted-packet counter; wraps.
- `misroute_cnt`  out  8  dropped-packet counter; saturates at 255.
- `misroute`  out  1  one-cycle pulse when a packet is dropped.

## Operation
- Packet fields: target row = `[pckg_sz-9:pckg_sz-12]`; target column = `[pckg_sz-13:pckg_sz-16]`. All other bits are passed through untouched.
- The FSM has three states: IDLE, CAPT, GAP.
  - IDLE: if `pndng`=1 and buffer count < `fifo_depth`, set `pop` to 1 and go to CAPT. Otherwise stay in IDLE with `pop`=0.
  - CAPT: `pop`=1 for this cycle. At the closing edge, sample `data_out`, set `pop` to 0, and go to GAP.
  - GAP: `pop`=0 for one cycle so the router can update its head and `pndng`. Then go to IDLE.
- Per-packet throughput is at most one packet every 3 cycles.
- Space check ignores a same-cycle local read. This is conservative: the buffer never overflows.
- Accept: the captured packet is written to the buffer, and `pkt_cnt` increments.
- Drop (only when address checking is compiled in; see Configuration): if the captured target differs from (`ROW`,`COL`), the packet is not written. `misroute_cnt` increments (saturating), and `misroute` pulses for the cycle after the capture edge.
- Local side:
  - A read occurs on an edge where `pkt_valid` and `pkt_ready` are both 1.
  - A simultaneous write and read leaves the count unchanged.
  - `pkt_ready` while empty has no effect.
- Pointers wrap modulo `fifo_depth`.
- `pndng` dropping while in CAPT or GAP: the packet sampled at the CAPT edge is still processed; no retry.

## Timing
- Reset values: state IDLE, `pop`=0, `pkt_valid`=0, `pkt_data`=0, `pkt_cnt`=0, `misroute_cnt`=0, `misroute`=0, buffer pointers and count 0.
- `pndng` sampled 1 in IDLE at edge N:
  - `pop` is high from edge N to edge N+1.
  - Data is captured at N+1.
  - `pkt_valid` rises after N+1 when the buffer was empty.
- `pop` is never high on two consecutive edges. At least two low cycles separate pulses.
- Reset asserted mid-operation: everything clears immediately and asynchronously, and `pop` drops without waiting for a clock. A packet in CAPT is lost. Buffered packets are discarded.
- After reset deasserts, the first `pop` can occur no earlier than one edge later.

## Configuration
- `MESH_SINK_ADDR_CHECK_EN` defined: the destination check is active, as described under Operation.
- Not defined: every captured packet is accepted regardless of address. `misroute_cnt` is tied to 0 and `misroute` is tied to 0.

## Test plan
- Single packet: `ROW`=`COL`=1, router presents a packet with target (1,1) and payload 0x2A, `pkt_ready`=1 → one `pop` pulse; `pkt_valid` for one cycle with matching `pkt_data`; `pkt_cnt`=1.
- Backpressure: hold `pkt_ready`=0 and keep `pndng`=1 → exactly 4 pops, then `pop` stays 0. Release `pkt_ready` → packets come out in order and popping resumes.
- Misroute: with `MESH_SINK_ADDR_CHECK_EN`, send target (2,3) → popped, `misroute` pulses once, `misroute_cnt`=1, `pkt_valid` stays 0. Without the macro, the same packet is delivered and `misroute_cnt`=0.
- Saturation: 300 misrouted packets → `misroute_cnt`=255. Then one good packet → `pkt_cnt`=1.
- Streaming: 20 back-to-back packets with `pkt_ready`=1 → the spacing between consecutive `pop` rising edges is exactly 3 cycles, and 20 packets come out in order.
- Reset: assert `reset`=0 during CAPT with 2 packets buffered → `pop`, `pkt_valid` and both counters are 0 immediately. After release, the next packet is delivered normally.
